brg_cfg_ctrl: RTL and testbench

- Configuration sequencer and bus arbiter for the SPART baud rate generator (brg).
- Selects a 16-bit divisor from the 2-bit baud select, then writes it into the brg: high byte first, then low byte, over the shared 8-bit data_out/load_high/load_low interface.
- Arbitrates that interface between the automatic sequence and host writes.
- Holds link_enable low until a complete divisor has been loaded, so the SPART tx/rx stay quiet while the divisor is invalid.

---
 rtl/brg_cfg_ctrl.sv | 148 ++++++++++++++
 tb/tb_brg_cfg_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/brg_cfg_ctrl.sv
// SPART baud-rate-generator configuration sequencer: loads the divisor selected by
// br_cfg high byte then low byte, and arbitrates the brg load bus with host writes.
module brg_cfg_ctrl #(
  parameter logic [15:0] DIV_4800  = 16'h0516,
  parameter logic [15:0] DIV_9600  = 16'h028B,
  parameter logic [15:0] DIV_19200 = 16'h0146,
  parameter logic [15:0] DIV_38400 = 16'h00A3,
  parameter int          SYNC_WAIT = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_br_cfg,
  input  logic       i_host_req,
  input  logic       i_host_sel,
  input  logic [7:0] i_host_data,
  output logic       o_host_gnt,
  output logic [7:0] o_data_out,
  output logic       o_load_high,
  output logic       o_load_low,
  output logic       o_cfg_busy,
  output logic       o_cfg_done,
  output logic       o_link_enable
);

  localparam int CW = (SYNC_WAIT < 1) ? 1 : $clog2(SYNC_WAIT + 1);

  typedef enum logic [2:0] {S_WAIT, S_HI, S_LO, S_DONE, S_IDLE, S_HOST} state_t;

  function automatic logic [15:0] f_div(input logic [1:0] sel);
    case (sel)
      2'b00:   f_div = DIV_4800;
      2'b01:   f_div = DIV_9600;
      2'b10:   f_div = DIV_19200;
      default: f_div = DIV_38400;
    endcase
  endfunction

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [1:0]    r_sel, w_sel;
  logic [1:0]    r_sync1, r_sync;
  logic [7:0]    r_data, w_data;
  logic          r_lh, w_lh, r_ll, w_ll, r_gnt, w_gnt;
  logic          r_done, w_done, r_link, w_link, r_busy, w_busy;
  logic [15:0]   w_div_sync, w_div_cur;

  assign w_div_sync = f_div(r_sync);
  assign w_div_cur  = f_div(r_sel);

  // Next-state logic also computes the outputs of the state being entered, so every
  // output is a flop and data_out falls back to zero whenever no strobe is set.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_sel   = r_sel;
    w_data  = 8'h00;
    w_lh    = 1'b0;
    w_ll    = 1'b0;
    w_gnt   = 1'b0;
    w_done  = 1'b0;
    w_link  = r_link;
    w_busy  = r_busy;
    case (r_state)
      S_WAIT: begin
        if (r_cnt == CW'(SYNC_WAIT)) begin
          w_state = S_HI;
          w_sel   = r_sync;
          w_lh    = 1'b1;
          w_data  = w_div_sync[15:8];
          w_link  = 1'b0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_HI: begin
        w_state = S_LO;
        w_ll    = 1'b1;
        w_data  = w_div_cur[7:0];
      end
      S_LO: begin
        w_state = S_DONE;
        w_done  = 1'b1;
        w_link  = 1'b1;
        w_busy  = 1'b0;
      end
      S_DONE: w_state = S_IDLE;
      S_IDLE: begin
        // Reconfiguration outranks the host; a pending host_req is served afterwards.
        if (r_sync != r_sel) begin
          w_state = S_HI;
          w_sel   = r_sync;
          w_busy  = 1'b1;
          w_lh    = 1'b1;
          w_data  = w_div_sync[15:8];
          w_link  = 1'b0;
        end else if (i_host_req) begin
          w_state = S_HOST;
          w_gnt   = 1'b1;
          w_data  = i_host_data;
          w_lh    = i_host_sel;
          w_ll    = ~i_host_sel;
          w_link  = ~i_host_sel;
        end
      end
      S_HOST:  w_state = S_IDLE;
      default: w_state = S_WAIT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_WAIT;
      r_cnt   <= '0;
      r_sel   <= 2'b00;
      r_sync1 <= 2'b00;
      r_sync  <= 2'b00;
      r_data  <= 8'h00;
      r_lh    <= 1'b0;
      r_ll    <= 1'b0;
      r_gnt   <= 1'b0;
      r_done  <= 1'b0;
      r_link  <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sel   <= w_sel;
      r_sync1 <= i_br_cfg;
      r_sync  <= r_sync1;
      r_data  <= w_data;
      r_lh    <= w_lh;
      r_ll    <= w_ll;
      r_gnt   <= w_gnt;
      r_done  <= w_done;
      r_link  <= w_link;
      r_busy  <= w_busy;
    end
  end

  assign o_host_gnt    = r_gnt;
  assign o_data_out    = r_data;
  assign o_load_high   = r_lh;
  assign o_load_low    = r_ll;
  assign o_cfg_busy    = r_busy;
  assign o_cfg_done    = r_done;
  assign o_link_enable = r_link;

endmodule

// File: tb/tb_brg_cfg_ctrl.sv
// Directed bench for brg_cfg_ctrl: power-up load, reconfiguration, host writes,
// arbitration, reset mid-sequence and br_cfg change during a sequence.
module tb_brg_cfg_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       host_req, host_sel;
  logic [7:0] host_data;
  logic       host_gnt, load_high, load_low, cfg_busy, cfg_done, link_enable;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  brg_cfg_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_br_cfg(br_cfg),
    .i_host_req(host_req), .i_host_sel(host_sel), .i_host_data(host_data),
    .o_host_gnt(host_gnt), .o_data_out(data_out),
    .o_load_high(load_high), .o_load_low(load_low),
    .o_cfg_busy(cfg_busy), .o_cfg_done(cfg_done), .o_link_enable(link_enable)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock edge, then the always-on strobe rules.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("excl", 16'(load_high & load_low), 16'h0);
    chk("dzero", (!load_high && !load_low) ? 16'(data_out) : 16'h0, 16'h0);
  endtask

  // Expected {gnt, lh, ll, done, link, busy} plus data_out.
  task automatic expect_o(input string tag, input logic [5:0] flags, input logic [7:0] d);
    chk(tag, {10'h0, host_gnt, load_high, load_low, cfg_done, link_enable, cfg_busy}, {10'h0, flags});
    chk({tag, "_d"}, 16'(data_out), 16'(d));
  endtask

  initial begin
    rst = 1'b1; br_cfg = 2'b01; host_req = 1'b0; host_sel = 1'b0; host_data = 8'h00;
    // power-up with 9600 selected
    #6;
    expect_o("rst", 6'b000001, 8'h00);
    #1 rst = 1'b0;
    tick(); expect_o("w1", 6'b000001, 8'h00);
    tick(); expect_o("w2", 6'b000001, 8'h00);
    tick(); expect_o("p_hi", 6'b010001, 8'h02);
    tick(); expect_o("p_lo", 6'b001001, 8'h8B);
    tick(); expect_o("p_dn", 6'b000110, 8'h00);
    tick(); expect_o("p_id", 6'b000010, 8'h00);

    // reconfigure 01 -> 11
    br_cfg = 2'b11;
    tick(); expect_o("r1", 6'b000010, 8'h00);
    tick(); expect_o("r2", 6'b000010, 8'h00);
    tick(); expect_o("r_hi", 6'b010001, 8'h00);
    tick(); expect_o("r_lo", 6'b001001, 8'hA3);
    tick(); expect_o("r_dn", 6'b000110, 8'h00);
    tick(); expect_o("r_id", 6'b000010, 8'h00);

    // host writes high then low byte
    host_req = 1'b1; host_sel = 1'b1; host_data = 8'h05;
    tick(); expect_o("h_hi", 6'b110000, 8'h05);
    host_sel = 1'b0; host_data = 8'h16;
    tick(); expect_o("h_gap", 6'b000000, 8'h00);
    tick(); expect_o("h_lo", 6'b101010, 8'h16);
    host_req = 1'b0;
    tick(); expect_o("h_id", 6'b000010, 8'h00);

    // host_req arrives with the br_sync mismatch: sequence first
    br_cfg = 2'b01;
    tick();
    tick(); expect_o("a_pre", 6'b000010, 8'h00);
    host_req = 1'b1; host_sel = 1'b0; host_data = 8'h8B;
    tick(); expect_o("a_hi", 6'b010001, 8'h02);
    tick(); expect_o("a_lo", 6'b001001, 8'h8B);
    tick(); expect_o("a_dn", 6'b000110, 8'h00);
    tick(); expect_o("a_id", 6'b000010, 8'h00);
    tick(); expect_o("a_gnt", 6'b101010, 8'h8B);
    host_req = 1'b0;
    tick(); expect_o("a_end", 6'b000010, 8'h00);

    // move to 4800, then reset during LO
    br_cfg = 2'b00;
    tick();
    tick();
    tick(); expect_o("x_hi", 6'b010001, 8'h05);
    tick(); expect_o("x_lo", 6'b001001, 8'h16);
    rst = 1'b1;
    #1 expect_o("x_rst", 6'b000001, 8'h00);
    #3 rst = 1'b0;
    tick(); expect_o("y1", 6'b000001, 8'h00);
    tick(); expect_o("y2", 6'b000001, 8'h00);
    tick(); expect_o("y_hi", 6'b010001, 8'h05);
    // br_cfg changes during HI: finish old divisor, then rerun
    br_cfg = 2'b10;
    tick(); expect_o("y_lo", 6'b001001, 8'h16);
    tick(); expect_o("y_dn", 6'b000110, 8'h00);
    tick(); expect_o("y_id", 6'b000010, 8'h00);
    tick(); expect_o("z_hi", 6'b010001, 8'h01);
    tick(); expect_o("z_lo", 6'b001001, 8'h46);
    tick(); expect_o("z_dn", 6'b000110, 8'h00);
    tick(); expect_o("z_id", 6'b000010, 8'h00);
    tick(); expect_o("z_st", 6'b000010, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
